// File: rtl/gpio_reg_responder.sv
// GPIO register responder: decodes register packets into a GPIO register file,
// drives pads, synchronises inputs, latches interrupts and returns read data.
module gpio_reg_responder #(
    parameter int N  = 32,
    parameter int AW = 32,
    parameter int PW = 2*AW+40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reg_access,
    input  logic [PW-1:0] reg_packet,
    output logic          reg_wait,
    output logic [N-1:0]  reg_rdata,
    output logic          reg_rvalid,
    input  logic          rsp_wait,
    input  logic [N-1:0]  gpio_in,
    output logic [N-1:0]  gpio_out,
    output logic [N-1:0]  gpio_en,
    output logic [N-1:0]  gpio_ilat,
    output logic          gpio_irq
);

    localparam logic [3:0] SEL_DIR     = 4'd0;
    localparam logic [3:0] SEL_IN      = 4'd1;
    localparam logic [3:0] SEL_OUT     = 4'd2;
    localparam logic [3:0] SEL_OUTCLR  = 4'd3;
    localparam logic [3:0] SEL_OUTSET  = 4'd4;
    localparam logic [3:0] SEL_OUTXOR  = 4'd5;
    localparam logic [3:0] SEL_IMASK   = 4'd6;
    localparam logic [3:0] SEL_ITYPE   = 4'd7;
    localparam logic [3:0] SEL_IPOL    = 4'd8;
    localparam logic [3:0] SEL_ILAT    = 4'd9;
    localparam logic [3:0] SEL_ILATCLR = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           rvalid_q, rvalid_d;
    logic           wait_q, wait_d;
    logic [N-1:0]   rdata_q, rdata_d;

    logic           req_valid_q, req_valid_d;
    logic           req_write_q, req_write_d;
    logic           req_legal_q, req_legal_d;
    logic [3:0]     req_sel_q, req_sel_d;
    logic [N-1:0]   req_data_q, req_data_d;

    logic [N-1:0]   dir_q, dir_d;
    logic [N-1:0]   out_q, out_d;
    logic [N-1:0]   imask_q, imask_d;
    logic [N-1:0]   itype_q, itype_d;
    logic [N-1:0]   ipol_q, ipol_d;
    logic [N-1:0]   ilat_q, ilat_d;
    logic [N-1:0]   s1_q, s2_q, p_q;
    logic [N-1:0]   evt;
    logic [N-1:0]   rd_val;

    logic           hold;
    logic           accept;
    logic           fire;
    logic           wr_fire;
    logic           rd_fire;
    logic           unused_pkt;

    // Only the select, mode, write flag and low data bits matter.
    assign unused_pkt = ^reg_packet;

    // While a response is stalled (or about to stall) the request stage freezes
    // and nothing new is taken, so a pending read can never overwrite held data.
    assign hold    = ((state_q == ST_RESP) && rsp_wait) || (state_q == ST_STALL);
    assign accept  = reg_access && !hold;
    assign fire    = req_valid_q && !hold;
    assign wr_fire = fire && req_write_q && req_legal_q;
    assign rd_fire = fire && !req_write_q;

    always_comb begin
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_legal_d = req_legal_q;
        req_sel_d   = req_sel_q;
        req_data_d  = req_data_q;
        if (accept) begin
            req_valid_d = 1'b1;
            req_write_d = reg_packet[0];
            req_legal_d = (reg_packet[2:1] == 2'b10);
            req_sel_d   = reg_packet[14:11];
            req_data_d  = reg_packet[AW+8 +: N];
        end else if (fire) begin
            req_valid_d = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_evt
            assign evt[gi] = itype_q[gi]
                ? (ipol_q[gi] ? (s2_q[gi] & ~p_q[gi]) : (~s2_q[gi] & p_q[gi]))
                : (ipol_q[gi] ? s2_q[gi] : ~s2_q[gi]);
        end
    endgenerate

    always_comb begin
        dir_d   = dir_q;
        out_d   = out_q;
        imask_d = imask_q;
        itype_d = itype_q;
        ipol_d  = ipol_q;
        ilat_d  = ilat_q;
        if (wr_fire) begin
            case (req_sel_q)
                SEL_DIR:     dir_d   = req_data_q;
                SEL_OUT:     out_d   = req_data_q;
                SEL_OUTCLR:  out_d   = out_q & ~req_data_q;
                SEL_OUTSET:  out_d   = out_q | req_data_q;
                SEL_OUTXOR:  out_d   = out_q ^ req_data_q;
                SEL_IMASK:   imask_d = req_data_q;
                SEL_ITYPE:   itype_d = req_data_q;
                SEL_IPOL:    ipol_d  = req_data_q;
                SEL_ILATCLR: ilat_d  = ilat_q & ~req_data_q;
                default:     ;
            endcase
        end
        // New unmasked events win over a same-cycle clear.
        ilat_d = ilat_d | (evt & ~imask_q);
    end

    always_comb begin
        rd_val = '0;
        if (req_legal_q) begin
            case (req_sel_q)
                SEL_DIR:   rd_val = dir_q;
                SEL_IN:    rd_val = s2_q;
                SEL_OUT:   rd_val = out_q;
                SEL_IMASK: rd_val = imask_q;
                SEL_ITYPE: rd_val = itype_q;
                SEL_IPOL:  rd_val = ipol_q;
                SEL_ILAT:  rd_val = ilat_q;
                default:   rd_val = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_fire) begin
                    state_d = ST_RESP;
                    rdata_d = rd_val;
                end
            end
            ST_RESP: begin
                if (rsp_wait) begin
                    state_d = ST_STALL;
                end else if (rd_fire) begin
                    rdata_d = rd_val;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (!rsp_wait) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rvalid_d = (state_d != ST_IDLE);
        wait_d   = (state_d == ST_STALL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rvalid_q    <= 1'b0;
            wait_q      <= 1'b0;
            rdata_q     <= '0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_legal_q <= 1'b0;
            req_sel_q   <= '0;
            req_data_q  <= '0;
            dir_q       <= '0;
            out_q       <= '0;
            imask_q     <= '1;
            itype_q     <= '0;
            ipol_q      <= '0;
            ilat_q      <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            p_q         <= '0;
        end else begin
            state_q     <= state_d;
            rvalid_q    <= rvalid_d;
            wait_q      <= wait_d;
            rdata_q     <= rdata_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_legal_q <= req_legal_d;
            req_sel_q   <= req_sel_d;
            req_data_q  <= req_data_d;
            dir_q       <= dir_d;
            out_q       <= out_d;
            imask_q     <= imask_d;
            itype_q     <= itype_d;
            ipol_q      <= ipol_d;
            ilat_q      <= ilat_d;
            s1_q        <= gpio_in;
            s2_q        <= s1_q;
            p_q         <= s2_q;
        end
    end

    assign reg_wait   = wait_q;
    assign reg_rvalid = rvalid_q;
    assign reg_rdata  = rdata_q;
    assign gpio_out   = out_q;
    assign gpio_en    = dir_q;
    assign gpio_ilat  = ilat_q;
    assign gpio_irq   = |(ilat_q & ~imask_q);

endmodule
